morse_symbol_framer: RTL
========================

Name: morse_symbol_framer

Overview:
- Timing-driven Morse front end. Takes the debounced key level and classifies each press as dot or dash from its measured duration. Classifies each release gap as intra-letter, letter or word gap.
- Assembles symbols into {count, pattern} code words and queues them in an internal FIFO with a valid/ready output. Sits between the button debouncer and the code-to-ASCII ROM/UART path.
- Successor to the fixed 5-symbol, externally-timed decoder/shift-register/counter chain. Generalised in symbol length, timing thresholds and buffering. Adds over-length error codes and FIFO drop reporting.

Parameters:
- MAX_SYM, 5, maximum symbols per character; legal range 1..14.
- CNT_W, $clog2(MAX_SYM+2), width of count field; all-ones value is reserved.
- UNIT_CYCLES, 5_000_000, clk cycles per Morse time unit.
- DASH_UNITS, 2, a press of >= DASH_UNITS units is a dash, otherwise a dot.
- LG_UNITS, 3, release of >= LG_UNITS units ends a letter.
- WG_UNITS, 7, release of >= WG_UNITS units ends a word; must exceed LG_UNITS.
- DEPTH, 8, FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- key  in  1  debounced key level, 1 = pressed
- code_data  out  CNT_W+MAX_SYM  FIFO head {count, pattern}
- code_valid  out  1  FIFO not empty
- code_ready  in  1  consumer accepts head when code_valid & code_ready
- cur_count  out  CNT_W  symbols in the letter being built
- cur_pattern  out  MAX_SYM  symbols of the letter being built
- sym_err  out  1  current letter exceeded MAX_SYM
- drop  out  1  sticky: a code was discarded because the FIFO was full
- fifo_full  out  1  FIFO holds DEPTH entries

Behaviour:
- Reset (reset_n=0 at clk edge): every output is 0. FIFO is emptied and all counters, key_q and the space_armed flag are cleared. Reset overrides everything, including a mid-press or mid-gap state.
- Timebase: prescaler counts 0..UNIT_CYCLES-1 and restarts on every key_q change. dur_units increments on prescaler wrap, saturates at WG_UNITS and is cleared on every key_q change.
- key is registered into key_q. An edge is key != key_q. All actions below take effect on the clock edge that detects the edge, so cur_* are visible 1 cycle after key first samples a new level.
- Falling edge (release): the symbol is dash if dur_units >= DASH_UNITS, else dot.
  - If cur_count < MAX_SYM: pattern <= {pattern[MAX_SYM-2:0], dash}; count++. Newest symbol is in bit 0, 1 = dash.
  - Otherwise set sym_err; pattern and count hold.
- Rising edge (press): the gap counter restarts. Any pending letter or word emission not yet reached is cancelled.
- While key_q=0, when dur_units first reaches LG_UNITS and (cur_count>0 or sym_err):
  - push {cur_count, pattern}; if sym_err, push the error code {all-ones, all-ones} instead;
  - clear cur_count, pattern and sym_err; set space_armed.
- While key_q=0, when dur_units first reaches WG_UNITS and space_armed=1: push the space code {all-ones, zeros} and clear space_armed. Consecutive word gaps emit only one space. Idle after reset emits nothing.
- FIFO:
  - Show-ahead: code_data is valid whenever code_valid=1; code_data = 0 when empty.
  - Pop on code_valid & code_ready.
  - A push while full is discarded and sets drop, unless a pop occurs in the same cycle, in which case the push is accepted.
  - A simultaneous push and pop when empty is impossible, because pop requires code_valid.
  - Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
- drop clears only on reset. code_data and code_valid must stay stable while code_valid & ~code_ready.

Test Plan:
- Parameters for all scenarios: UNIT_CYCLES=4, MAX_SYM=5, DEPTH=4, DASH=2, LG=3, WG=7.
- "A": press 4 clk, release 8, press 12, release 40 -> one push of code_data=8'b010_00001 after the 3-unit gap, then 8'b111_00000 (space) at 7 units; code_valid held until code_ready.
- Reset mid-press: key high 6 clk, then reset_n=0 for 1 cycle, then release -> cur_count=0, no code pushed, all outputs 0.
- Six dots, then a letter gap -> sym_err=1 after the 6th release; pushed code is 8'hFF; cur_count returns to 0.
- With code_ready=0, send 5 single-dot letters -> fifo_full=1 after the 4th, drop=1 after the 5th. Then raise code_ready for 1 cycle together with a push -> push accepted, drop stays 1.
- Two word gaps separated by no symbols -> exactly one 8'hE0 pushed.
- Press at 2 units into a gap -> no letter emitted; the next symbol appends: "dot, gap 2 units, dash" gives cur_count=2, cur_pattern=5'b00001.

Source files
------------

// File: rtl/morse_symbol_framer.sv
// Morse key front end: times presses and gaps, builds {count, pattern} code
// words and queues them in a show-ahead FIFO with a valid/ready output.
module morse_symbol_framer #(
  parameter int MAX_SYM     = 5,
  parameter int CNT_W       = $clog2(MAX_SYM + 2),
  parameter int UNIT_CYCLES = 5_000_000,
  parameter int DASH_UNITS  = 2,
  parameter int LG_UNITS    = 3,
  parameter int WG_UNITS    = 7,
  parameter int DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     key,
  output logic [CNT_W+MAX_SYM-1:0] code_data,
  output logic                     code_valid,
  input  logic                     code_ready,
  output logic [CNT_W-1:0]         cur_count,
  output logic [MAX_SYM-1:0]       cur_pattern,
  output logic                     sym_err,
  output logic                     drop,
  output logic                     fifo_full
);

  localparam int CW = CNT_W + MAX_SYM;
  localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int DW = $clog2(WG_UNITS + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PW-1:0]    PRE_LAST  = PW'(UNIT_CYCLES - 1);
  localparam logic [DW-1:0]    DASH_D    = DW'(DASH_UNITS);
  localparam logic [DW-1:0]    LG_LAST   = DW'(LG_UNITS - 1);
  localparam logic [DW-1:0]    WG_LAST   = DW'(WG_UNITS - 1);
  localparam logic [DW-1:0]    WG_D      = DW'(WG_UNITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_SYM);
  localparam logic [CW-1:0]    ERR_CODE  = '1;
  localparam logic [CW-1:0]    SPACE_CODE = {{CNT_W{1'b1}}, {MAX_SYM{1'b0}}};

  logic               key_q, key_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [DW-1:0]      dur_q, dur_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [MAX_SYM-1:0] pattern_q, pattern_d;
  logic               err_q, err_d;
  logic               armed_q, armed_d;
  logic               drop_q, drop_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      mem_q [DEPTH];

  logic          key_edge, wrap, dash_sym;
  logic          letter_evt, space_evt;
  logic          push, push_ok, pop, empty, full;
  logic [CW-1:0] push_data;

  assign key_edge = key ^ key_q;
  assign wrap     = (presc_q == PRE_LAST);
  assign dash_sym = (dur_q >= DASH_D);

  // Gap events fire on the wrap that moves dur_units onto the threshold;
  // a key edge in the same cycle wins and cancels them.
  assign letter_evt = !key_edge && !key_q && wrap && (dur_q == LG_LAST)
                      && ((count_q != '0) || err_q);
  assign space_evt  = !key_edge && !key_q && wrap && (dur_q == WG_LAST) && armed_q;

  assign push      = letter_evt || space_evt;
  assign push_data = space_evt ? SPACE_CODE :
                     err_q     ? ERR_CODE   : {count_q, pattern_q};

  always_comb begin
    key_d     = key;
    presc_d   = presc_q;
    dur_d     = dur_q;
    count_d   = count_q;
    pattern_d = pattern_q;
    err_d     = err_q;
    armed_d   = armed_q;

    if (key_edge) begin
      presc_d = '0;
      dur_d   = '0;
      if (key_q && !key) begin
        if (count_q < CNT_MAX) begin
          pattern_d = MAX_SYM'({pattern_q, dash_sym});
          count_d   = count_q + CNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (wrap) begin
      presc_d = '0;
      if (dur_q != WG_D) dur_d = dur_q + DW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (letter_evt) begin
      count_d   = '0;
      pattern_d = '0;
      err_d     = 1'b0;
      armed_d   = 1'b1;
    end
    if (space_evt) armed_d = 1'b0;
  end

  // Extra pointer bit separates full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && code_ready;
  assign push_ok = push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (push && !push_ok) drop_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_q     <= 1'b0;
      presc_q   <= '0;
      dur_q     <= '0;
      count_q   <= '0;
      pattern_q <= '0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
      drop_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      key_q     <= key_d;
      presc_q   <= presc_d;
      dur_q     <= dur_d;
      count_q   <= count_d;
      pattern_q <= pattern_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
      drop_q    <= drop_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (reset_n && push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign code_valid  = !empty;
  assign code_data   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_full   = full;
  assign cur_count   = count_q;
  assign cur_pattern = pattern_q;
  assign sym_err     = err_q;
  assign drop        = drop_q;

endmodule
